gb_ofmap_acc: RTL and testbench
===============================

# gb_ofmap_acc

Parametrised output-feature-map global buffer with an accumulating write port, a single-word read port, and an X_DIM-lane wide read port with a valid/ready handshake. It sits between the PE array and the inter-layer datapath. PEs stream partial sums in with accumulate, and the next layer drains completed ofmap rows through the wide port. A sequential clear engine zeroes the array between layers.

## Interface
- DATA_BITWIDTH, 16, word width
- ADDR_BITWIDTH, 10, address width; DEPTH = 2^ADDR_BITWIDTH words
- X_DIM, 3, lanes on wide read port, 1..8
- ACC_SAT, 0, accumulate mode: 0 = two's-complement wrap, 1 = signed saturate
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- w_en  in  1  write request; accepted when w_en && w_ready
- w_acc  in  1  1 = mem[w_addr] += w_data, 0 = plain overwrite
- w_addr  in  ADDR_BITWIDTH  write address
- w_data  in  DATA_BITWIDTH  write data / addend (signed)
- w_ready  out  1  = !busy
- read_req  in  1  single-word read request
- r_addr  in  ADDR_BITWIDTH  read address
- r_data  out  DATA_BITWIDTH  read data; holds last value when idle
- r_valid  out  1  pulses 1 cycle after read_req
- rw_req  in  1  wide read request
- rw_addr  in  ADDR_BITWIDTH  wide read base address
- rw_req_ready  out  1  = !busy && (!rw_valid || rw_ack)
- rw_data  out  DATA_BITWIDTH*X_DIM  lane i = mem[(rw_addr+i) mod DEPTH], lane 0 in LSBs
- rw_valid  out  1  wide data valid; held until rw_ack
- rw_ack  in  1  consumer accepts rw_data
- clr_start  in  1  start clear sweep; honoured only when !busy
- busy  out  1  clear sweep in progress

## Operation
- Write pipeline, 2 stages. S1 latches addr/data/acc and reads mem. S2 computes the result and commits at the end of S2. Result = w_data (plain) or old + w_data (acc).
- Forwarding: if the S1 address equals the S2 address, S1 uses the S2 result instead of the mem value. Back-to-back accumulates to one address must sum exactly.
- Arithmetic: sum computed at DATA_BITWIDTH+1 bits. ACC_SAT=0 truncates. ACC_SAT=1 clamps to [-2^(W-1), 2^(W-1)-1].
- Reads never forward from the write pipeline. They see only committed contents (read-before-write on a same-cycle collision).
- Wide read: one-deep output register. It loads on an accepted rw_req and holds while rw_valid && !rw_ack. Addresses wrap modulo DEPTH.
- FSM states IDLE and CLEAR.
  - IDLE→CLEAR on clr_start.
  - In CLEAR, a counter writes 0 to addresses 0..DEPTH-1, one per cycle.
  - CLEAR→IDLE after address DEPTH-1 is written.
  - clr_start while busy is ignored.
- Clear vs in-flight writes: a sweep write beats an S2 commit in the same cycle. Writes accepted up to and including the clr_start cycle are thereby lost. After clear, all words are 0.
- Single-word reads remain serviced during CLEAR and return current contents. Wide reads are blocked (rw_req_ready=0), but an already-valid rw_data stays valid until acked.

## Timing
- Single read: read_req at cycle t → r_data/r_valid at t+1.
- Wide read: accept at t → rw_valid at t+1. Accept and ack in the same cycle allow 1 wide word/cycle throughput.
- Write: accepted at t → committed at end of t+1 → visible to a read issued at t+2.
- Clear: clr_start at t → busy=1 from t+1 through t+DEPTH → busy=0 at t+DEPTH+1.
- Reset values: r_data=0, r_valid=0, rw_data=0, rw_valid=0, busy=0, FSM=IDLE, S1/S2 valid=0.
- Memory contents are not reset. A reset mid-sweep aborts it, leaving the array partially cleared, and in-flight writes are dropped.

## Structure
- Package gb_ofmap_pkg holds:
  - FSM state encoding (IDLE, CLEAR)
  - saturating add function parametrised by width
  - lane-extraction helper for wide data
- Sub-module gb_acc_pipe: the 2-stage read-modify-write pipeline with forwarding. Its ports are memory read address/data, commit strobe/address/data, and a kill input driven by the sweep.
- Top level holds the memory array, both read ports, the wide output register, and the clear FSM/counter.

## Test plan
- Accumulate: write 5 to addr 7 (w_acc=0), then accumulate 3, 4, -2 on consecutive cycles → read at addr 7 returns 10.
- Saturation: ACC_SAT=1, W=16; mem[0]=32760, accumulate 100 → 32767. With ACC_SAT=0 the same stimulus gives -32676.
- Wide wrap: X_DIM=3, mem[1022]=A, mem[1023]=B, mem[0]=C; rw_req at 1022 → rw_data={C,B,A}. Hold rw_ack=0 for 3 cycles → data stable, rw_req_ready=0.
- Collision: write 9 to addr 4 at t, read addr 4 at t+1 → old value; read at t+2 → 9.
- Clear: DEPTH=16; write nonzero everywhere, pulse clr_start → busy for exactly 16 cycles, w_ready=0 throughout, all reads after return 0. A write accepted in the clr_start cycle must also read 0.
- Reset mid-clear at sweep index 5 → busy=0 and rw_valid=0 next cycle; addr 0..4 read 0, addr 5+ keep prior values.

Source files
------------

// File: rtl/gb_ofmap_pkg.sv
// Shared types and arithmetic helpers for the ofmap global buffer.
package gb_ofmap_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  localparam int unsigned ACC_MAXW = 32;
  localparam int unsigned LANE_MAX = 8;

  // Operands arrive sign-extended to ACC_MAXW; result is a w-bit value sign-extended to ACC_MAXW.
  function automatic logic [ACC_MAXW-1:0] acc_add(input logic [ACC_MAXW-1:0] a,
                                                  input logic [ACC_MAXW-1:0] b,
                                                  input int unsigned w,
                                                  input logic sat);
    logic signed [ACC_MAXW:0]   sum;
    logic signed [ACC_MAXW:0]   hi;
    logic signed [ACC_MAXW:0]   lo;
    logic signed [ACC_MAXW:0]   one;
    logic signed [ACC_MAXW-1:0] res;
    one = {{ACC_MAXW{1'b0}}, 1'b1};
    sum = $signed({a[ACC_MAXW-1], a}) + $signed({b[ACC_MAXW-1], b});
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    res = sum[ACC_MAXW-1:0];
    if (sat) begin
      if (sum > hi)      res = hi[ACC_MAXW-1:0];
      else if (sum < lo) res = lo[ACC_MAXW-1:0];
    end else begin
      res = (res <<< (ACC_MAXW - w)) >>> (ACC_MAXW - w);
    end
    return res;
  endfunction

  function automatic logic [ACC_MAXW-1:0] lane_get(input logic [LANE_MAX*ACC_MAXW-1:0] bus,
                                                   input int unsigned lane,
                                                   input int unsigned w);
    logic [LANE_MAX*ACC_MAXW-1:0] sh;
    logic [ACC_MAXW-1:0]          mask;
    sh   = bus >> (lane * w);
    mask = (w >= ACC_MAXW) ? '1 : ((ACC_MAXW'(1) << w) - ACC_MAXW'(1));
    return sh[ACC_MAXW-1:0] & mask;
  endfunction

endpackage

// File: rtl/gb_acc_pipe.sv
// Two-stage read-modify-write pipeline: S1 reads memory (or forwards S2), S2 computes and commits.
module gb_acc_pipe
  import gb_ofmap_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 10,
  parameter int unsigned ACC_SAT       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr,
  input  logic                     i_acc,
  input  logic [ADDR_BITWIDTH-1:0] i_addr,
  input  logic [DATA_BITWIDTH-1:0] i_data,
  output logic [ADDR_BITWIDTH-1:0] o_mem_raddr,
  input  logic [DATA_BITWIDTH-1:0] i_mem_rdata,
  input  logic                     i_kill,
  output logic                     o_commit,
  output logic [ADDR_BITWIDTH-1:0] o_commit_addr,
  output logic [DATA_BITWIDTH-1:0] o_commit_data
);

  logic                              r_s2_valid;
  logic                              r_s2_acc;
  logic [ADDR_BITWIDTH-1:0]          r_s2_addr;
  logic [DATA_BITWIDTH-1:0]          r_s2_data;
  logic [DATA_BITWIDTH-1:0]          r_s2_old;
  logic [DATA_BITWIDTH-1:0]          w_s1_old;
  logic [DATA_BITWIDTH-1:0]          w_s2_result;
  logic [DATA_BITWIDTH-1:0]          w_sum;
  logic [ACC_MAXW-DATA_BITWIDTH-1:0] w_sum_unused;

  assign o_mem_raddr = i_addr;
  // The S2 result is not yet in memory, so a same-address S1 must take it directly.
  assign w_s1_old = (r_s2_valid && (r_s2_addr == i_addr)) ? w_s2_result : i_mem_rdata;

  assign {w_sum_unused, w_sum} = acc_add(ACC_MAXW'($signed(r_s2_old)),
                                         ACC_MAXW'($signed(r_s2_data)),
                                         DATA_BITWIDTH, ACC_SAT != 0);
  assign w_s2_result = r_s2_acc ? w_sum : r_s2_data;

  always_ff @(posedge clk) begin
    if (reset) r_s2_valid <= 1'b0;
    else       r_s2_valid <= i_wr;
  end

  always_ff @(posedge clk) begin
    if (i_wr) begin
      r_s2_acc  <= i_acc;
      r_s2_addr <= i_addr;
      r_s2_data <= i_data;
      r_s2_old  <= w_s1_old;
    end
  end

  assign o_commit      = r_s2_valid && !i_kill;
  assign o_commit_addr = r_s2_addr;
  assign o_commit_data = w_s2_result;

endmodule

// File: rtl/gb_ofmap_acc.sv
// Ofmap global buffer: accumulating write pipe, single and wide read ports, sequential clear sweep.
module gb_ofmap_acc
  import gb_ofmap_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 10,
  parameter int unsigned X_DIM         = 3,
  parameter int unsigned ACC_SAT       = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_en,
  input  logic                             w_acc,
  input  logic [ADDR_BITWIDTH-1:0]         w_addr,
  input  logic [DATA_BITWIDTH-1:0]         w_data,
  output logic                             w_ready,
  input  logic                             read_req,
  input  logic [ADDR_BITWIDTH-1:0]         r_addr,
  output logic [DATA_BITWIDTH-1:0]         r_data,
  output logic                             r_valid,
  input  logic                             rw_req,
  input  logic [ADDR_BITWIDTH-1:0]         rw_addr,
  output logic                             rw_req_ready,
  output logic [DATA_BITWIDTH*X_DIM-1:0]   rw_data,
  output logic                             rw_valid,
  input  logic                             rw_ack,
  input  logic                             clr_start,
  output logic                             busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITWIDTH;

  logic [DATA_BITWIDTH-1:0]       r_mem [DEPTH];
  clr_state_t                     r_state;
  logic                           r_busy;
  logic [ADDR_BITWIDTH-1:0]       r_clr_cnt;
  logic [DATA_BITWIDTH-1:0]       r_rd_data;
  logic                           r_rd_valid;
  logic [DATA_BITWIDTH*X_DIM-1:0] r_rw_data;
  logic                           r_rw_valid;
  logic [DATA_BITWIDTH*X_DIM-1:0] w_rw_lanes;
  logic                           w_wr_accept;
  logic                           w_rw_accept;
  logic                           w_sweep;
  logic                           w_commit;
  logic [ADDR_BITWIDTH-1:0]       w_pipe_raddr;
  logic [ADDR_BITWIDTH-1:0]       w_commit_addr;
  logic [DATA_BITWIDTH-1:0]       w_commit_data;

  assign w_ready      = !r_busy;
  assign busy         = r_busy;
  assign w_wr_accept  = w_en && !r_busy;
  assign rw_req_ready = !r_busy && (!r_rw_valid || rw_ack);
  assign w_rw_accept  = rw_req && rw_req_ready;
  assign r_data       = r_rd_data;
  assign r_valid      = r_rd_valid;
  assign rw_data      = r_rw_data;
  assign rw_valid     = r_rw_valid;

  gb_acc_pipe #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .ADDR_BITWIDTH(ADDR_BITWIDTH),
    .ACC_SAT      (ACC_SAT)
  ) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .i_wr         (w_wr_accept),
    .i_acc        (w_acc),
    .i_addr       (w_addr),
    .i_data       (w_data),
    .o_mem_raddr  (w_pipe_raddr),
    .i_mem_rdata  (r_mem[w_pipe_raddr]),
    .i_kill       (r_busy),
    .o_commit     (w_commit),
    .o_commit_addr(w_commit_addr),
    .o_commit_data(w_commit_data)
  );

  // Sweep write has priority over a pipeline commit; a reset cycle writes nothing.
  assign w_sweep = r_busy && !reset;

  always_ff @(posedge clk) begin
    if (w_sweep)                 r_mem[r_clr_cnt]     <= '0;
    else if (w_commit && !reset) r_mem[w_commit_addr] <= w_commit_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == '1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= read_req;
      if (read_req) r_rd_data <= r_mem[r_addr];
    end
  end

  always_comb begin
    w_rw_lanes = '0;
    for (int unsigned i = 0; i < X_DIM; i++) begin
      w_rw_lanes[i*DATA_BITWIDTH +: DATA_BITWIDTH] = r_mem[rw_addr + ADDR_BITWIDTH'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rw_data  <= '0;
      r_rw_valid <= 1'b0;
    end else if (w_rw_accept) begin
      r_rw_data  <= w_rw_lanes;
      r_rw_valid <= 1'b1;
    end else if (rw_ack) begin
      r_rw_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_ofmap_acc.sv
// Scoreboard bench for gb_ofmap_acc: saturating and wrapping instances driven in lockstep.
module tb_gb_ofmap_acc;
  import gb_ofmap_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int X     = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, w_en, w_acc, read_req, rw_req, rw_ack, clr_start;
  logic [AW-1:0] w_addr, r_addr, rw_addr;
  logic [DW-1:0] w_data;

  logic            w_ready_s, r_valid_s, rw_req_ready_s, rw_valid_s, busy_s;
  logic            w_ready_w, r_valid_w, rw_req_ready_w, rw_valid_w, busy_w;
  logic [DW-1:0]   r_data_s, r_data_w;
  logic [DW*X-1:0] rw_data_s, rw_data_w;

  gb_ofmap_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_DIM(X), .ACC_SAT(1)) u_sat (
    .clk(clk), .reset(reset), .w_en(w_en), .w_acc(w_acc), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready_s), .read_req(read_req), .r_addr(r_addr), .r_data(r_data_s),
    .r_valid(r_valid_s), .rw_req(rw_req), .rw_addr(rw_addr), .rw_req_ready(rw_req_ready_s),
    .rw_data(rw_data_s), .rw_valid(rw_valid_s), .rw_ack(rw_ack), .clr_start(clr_start),
    .busy(busy_s));

  gb_ofmap_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_DIM(X), .ACC_SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .w_en(w_en), .w_acc(w_acc), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready_w), .read_req(read_req), .r_addr(r_addr), .r_data(r_data_w),
    .r_valid(r_valid_w), .rw_req(rw_req), .rw_addr(rw_addr), .rw_req_ready(rw_req_ready_w),
    .rw_data(rw_data_w), .rw_valid(rw_valid_w), .rw_ack(rw_ack), .clr_start(clr_start),
    .busy(busy_w));

  // Reference model: lmem is the program-order view, cmem what a read can observe.
  logic [DW-1:0]   cmem_s [DEPTH], lmem_s [DEPTH], cmem_w [DEPTH], lmem_w [DEPTH];
  bit              pend_v;
  int              pend_a;
  logic [DW-1:0]   pend_ds, pend_dw;
  bit              busy_m, rwv_m;
  int              clr_idx;
  logic [DW-1:0]   rq_s[$], rq_w[$];
  logic [DW*X-1:0] wq_s[$], wq_w[$];
  int              checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] madd(logic [DW-1:0] o, logic [DW-1:0] d, bit sat);
    int s;
    s = int'($signed(o)) + int'($signed(d));
    if (sat) begin
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
    end
    return s[DW-1:0];
  endfunction

  task automatic model_update();
    if (reset) begin
      pend_v = 0; busy_m = 0; clr_idx = 0; rwv_m = 0;
      for (int i = 0; i < DEPTH; i++) begin lmem_s[i] = cmem_s[i]; lmem_w[i] = cmem_w[i]; end
      wq_s.delete(); wq_w.delete();
      return;
    end
    if (pend_v && !busy_m) begin cmem_s[pend_a] = pend_ds; cmem_w[pend_a] = pend_dw; end
    if (busy_m) begin
      cmem_s[clr_idx] = '0; cmem_w[clr_idx] = '0; lmem_s[clr_idx] = '0; lmem_w[clr_idx] = '0;
    end
    pend_v = 0;
    if (w_en && !busy_m) begin
      pend_a  = int'(w_addr);
      pend_ds = w_acc ? madd(lmem_s[pend_a], w_data, 1) : w_data;
      pend_dw = w_acc ? madd(lmem_w[pend_a], w_data, 0) : w_data;
      lmem_s[pend_a] = pend_ds; lmem_w[pend_a] = pend_dw;
      pend_v = 1;
    end
    if (rw_req && !busy_m && (!rwv_m || rw_ack)) rwv_m = 1;
    else if (rw_ack) rwv_m = 0;
    if (busy_m) begin
      if (clr_idx == DEPTH - 1) busy_m = 0;
      else clr_idx++;
    end else if (clr_start) begin
      busy_m = 1; clr_idx = 0;
    end
  endtask

  task automatic cyc(bit rst, bit we, bit acc, int wa, int wd, bit rd, int ra,
                     bit rw, int rwa, bit ack, bit clr);
    logic [DW*X-1:0] ls, lw;
    reset = rst; w_en = we; w_acc = acc; w_addr = AW'(wa); w_data = DW'(wd);
    read_req = rd; r_addr = AW'(ra); rw_req = rw; rw_addr = AW'(rwa); rw_ack = ack;
    clr_start = clr;
    #1;
    if (!rst) begin
      chk("rw_req_ready_s", 64'(rw_req_ready_s), 64'(!busy_m && (!rwv_m || ack)));
      chk("rw_req_ready_w", 64'(rw_req_ready_w), 64'(!busy_m && (!rwv_m || ack)));
      if (rd) begin rq_s.push_back(cmem_s[ra % DEPTH]); rq_w.push_back(cmem_w[ra % DEPTH]); end
      if (rw && !busy_m && (!rwv_m || ack)) begin
        for (int i = 0; i < X; i++) begin
          ls[i*DW +: DW] = cmem_s[(rwa + i) % DEPTH];
          lw[i*DW +: DW] = cmem_w[(rwa + i) % DEPTH];
        end
        wq_s.push_back(ls); wq_w.push_back(lw);
      end
    end
    @(posedge clk); #1;
    model_update();
    chk("busy_s", 64'(busy_s), 64'(busy_m));
    chk("busy_w", 64'(busy_w), 64'(busy_m));
    chk("w_ready_s", 64'(w_ready_s), 64'(!busy_m));
    chk("rw_valid_s", 64'(rw_valid_s), 64'(rwv_m));
    chk("rw_valid_w", 64'(rw_valid_w), 64'(rwv_m));
  endtask

  task automatic idle();              cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic wr(int a, int d, bit acc); cyc(0, 1, acc, a, d, 0, 0, 0, 0, 1, 0); endtask
  task automatic rd(int a);           cyc(0, 0, 0, 0, 0, 1, a, 0, 0, 1, 0); endtask

  always @(negedge clk) begin
    if (r_valid_s) begin
      if (rq_s.size() == 0) begin checks++; errors++; $display("FAIL r_valid_s unexpected at %0t", $time); end
      else chk("r_data_s", 64'(r_data_s), 64'(rq_s.pop_front()));
    end
    if (r_valid_w) begin
      if (rq_w.size() == 0) begin checks++; errors++; $display("FAIL r_valid_w unexpected at %0t", $time); end
      else chk("r_data_w", 64'(r_data_w), 64'(rq_w.pop_front()));
    end
    if (rw_valid_s) begin
      if (wq_s.size() == 0) begin checks++; errors++; $display("FAIL rw_valid_s unexpected at %0t", $time); end
      else begin
        for (int i = 0; i < X; i++)
          chk($sformatf("rw_lane%0d_s", i), 64'(lane_get(256'(rw_data_s), i, DW)),
              64'(lane_get(256'(wq_s[0]), i, DW)));
        if (rw_ack) void'(wq_s.pop_front());
      end
    end
    if (rw_valid_w) begin
      if (wq_w.size() == 0) begin checks++; errors++; $display("FAIL rw_valid_w unexpected at %0t", $time); end
      else begin
        chk("rw_data_w", 64'(rw_data_w), 64'(wq_w[0]));
        if (rw_ack) void'(wq_w.pop_front());
      end
    end
  end

  initial begin
    int n;
    pend_v = 0; busy_m = 0; rwv_m = 0; clr_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cmem_s[i] = '0; cmem_w[i] = '0; lmem_s[i] = '0; lmem_w[i] = '0;
    end
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_r_data", 64'(r_data_s), 64'd0);
    chk("reset_r_valid", 64'(r_valid_s), 64'd0);
    chk("reset_rw_data", 64'(rw_data_w), 64'd0);
    chk("reset_busy", 64'(busy_s), 64'd0);

    // Initial sweep gives the array known contents.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (DEPTH + 1) idle();

    // Accumulate chain: expect 10 at addr 7
    wr(7, 5, 0); wr(7, 3, 1); wr(7, 4, 1); wr(7, -2, 1); idle(); rd(7); idle();
    // Saturate vs wrap
    wr(0, 32760, 0); wr(0, 100, 1); idle(); rd(0); idle();
    // Wide wrap and hold
    wr(14, 16'h0A0A, 0); wr(15, 16'h0B0B, 0); wr(0, 16'h0C0C, 0); idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    idle(); idle();
    // Write/read collision
    wr(4, 9, 0); rd(4); rd(4); idle();

    // Clear with nonzero contents and a write in the clr_start cycle
    for (int a = 0; a < DEPTH; a++) wr(a, a * 37 + 1, 0);
    cyc(0, 1, 0, 3, 77, 0, 0, 0, 0, 1, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_s) n++;
      cyc(0, 1, $urandom % 2, $urandom % DEPTH, $urandom, 1, $urandom % DEPTH, 1, 0, 1, 0);
      if (!busy_s && n > 0) break;
    end
    chk("clear_len", 64'(n), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) rd(a);

    // Randomised traffic
    for (int k = 0; k < 800; k++)
      cyc(0, $urandom % 3 != 0, $urandom % 2, $urandom % DEPTH, $urandom,
          $urandom % 2, $urandom % DEPTH, $urandom % 2, $urandom % DEPTH,
          $urandom % 4 != 0, $urandom % 150 == 0);
    repeat (DEPTH + 2) idle();

    // Reset at sweep index 5 with a wide word still pending
    for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(1, 60000), 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_r_data", 64'(r_data_s), 64'd0);
    for (int a = 0; a < DEPTH; a++) rd(a);
    idle(); idle();

    chk("rq_drain_s", 64'(rq_s.size()), 64'd0);
    chk("rq_drain_w", 64'(rq_w.size()), 64'd0);
    chk("wq_drain_s", 64'(wq_s.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
